// File: rtl/instr_seq_pkg.sv
// Shared types and defaults for the instrumented-adder measurement sequencer.
// Optional averaging is enabled with INSTR_SEQ_AVG_EN.
package instr_seq_pkg;

    localparam int DATA_W       = 32;
    localparam int WIN_W_DEF    = 16;
    localparam int SETTLE_DEF   = 4;
    localparam int AVG_LOG2_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STOP,
        CAPTURE,
        RESP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [DATA_W-1:0]    ext_b;
        logic [DATA_W-1:0]    ring_b;
        logic [DATA_W-1:0]    out_b;
        logic [WIN_W_DEF-1:0] window;
    } cmd_t;

    // A zero-length window still runs the ring for one clock.
    function automatic logic [WIN_W_DEF-1:0] win_len(
        input logic [WIN_W_DEF-1:0] w
    );
        return (w == '0) ? WIN_W_DEF'(1) : w;
    endfunction

endpackage

// File: rtl/instr_seq_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval.
// A load of N therefore spans exactly N cycles of the owning state.
module instr_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/instr_adder_sequencer.sv
// Command/response measurement sequencer for the instrumented ring-oscillator adder.
// Define INSTR_SEQ_AVG_EN to average 2^AVG_LOG2 passes per command.
module instr_adder_sequencer
    import instr_seq_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int WIN_W    = WIN_W_DEF,
    parameter int SETTLE   = SETTLE_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_ext_b,
    input  logic [WIDTH-1:0] cmd_ring_b,
    input  logic [WIDTH-1:0] cmd_out_b,
    input  logic [WIN_W-1:0] cmd_window,
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic [WIDTH-1:0] a_input_ext_bit_b,
    output logic [WIDTH-1:0] a_input_ring_bit_b,
    output logic [WIDTH-1:0] s_output_bit_b,
    output logic             ring_en,
    output logic             count_clr,
    input  logic [31:0]      ring_count,
    input  logic [WIDTH-1:0] sum_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_count,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             busy
);

    localparam cmd_t CMD_RST = '{
        a:      '0,
        b:      '0,
        ext_b:  '1,
        ring_b: '1,
        out_b:  '1,
        window: '0
    };

    state_t     state_q, state_d;
    cmd_t       cmd_q, cmd_in;
    logic       tmr_load, tmr_done;
    logic [WIN_W-1:0] tmr_val;
    logic       accept, capture, restart, last_pass;
    logic [31:0] cap_count;

    assign cmd_in = '{
        a:      cmd_a,
        b:      cmd_b,
        ext_b:  cmd_ext_b,
        ring_b: cmd_ring_b,
        out_b:  cmd_out_b,
        window: cmd_window
    };

    instr_seq_timer #(
        .W(WIN_W)
    ) u_timer (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .load (tmr_load),
        .value(tmr_val),
        .done (tmr_done)
    );

`ifdef INSTR_SEQ_AVG_EN
    logic [AVG_LOG2-1:0]        pass_q;
    logic [31+AVG_LOG2:0]       acc_q, acc_sum;

    assign acc_sum   = acc_q + {{AVG_LOG2{1'b0}}, ring_count};
    assign last_pass = &pass_q;
    assign cap_count = acc_sum[AVG_LOG2 +: 32];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (accept) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (capture) begin
            pass_q <= pass_q + 1'b1;
            acc_q  <= last_pass ? '0 : acc_sum;
        end
    end
`else
    logic unused_avg;

    assign unused_avg = (AVG_LOG2 != 0);
    assign last_pass  = 1'b1;
    assign cap_count  = ring_count;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        capture  = 1'b0;
        restart  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE + 1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = win_len(cmd_q.window);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE);
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (tmr_done) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                if (last_pass) begin
                    state_d = RESP;
                end else begin
                    restart  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE + 1);
                    state_d  = LOAD;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Adder-facing strobes are registered so they are glitch-free at the macro.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_RST;
            ring_en   <= 1'b0;
            count_clr <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_count <= '0;
            rsp_sum   <= '0;
        end else begin
            state_q   <= state_d;
            ring_en   <= (state_d == RUN);
            count_clr <= accept | restart;
            rsp_valid <= (state_d == RESP);
            if (accept) begin
                cmd_q <= cmd_in;
            end
            if (capture && last_pass) begin
                rsp_count <= cap_count;
                rsp_sum   <= sum_in;
            end
        end
    end

    assign a_input            = cmd_q.a;
    assign b_input            = cmd_q.b;
    assign a_input_ext_bit_b  = cmd_q.ext_b;
    assign a_input_ring_bit_b = cmd_q.ring_b;
    assign s_output_bit_b     = cmd_q.out_b;
    assign cmd_ready          = (state_q == IDLE);
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_instr_adder_sequencer.sv
// Self-checking bench for instr_adder_sequencer with a counting ring stub.
// Expectations come from a cycle-budget model of one measurement per command.
module tb_instr_adder_sequencer;

`ifdef INSTR_SEQ_AVG_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 1;
`endif
    localparam int SETTLE = 4;
    localparam int BOUND  = 2000;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b, cmd_ext_b, cmd_ring_b, cmd_out_b;
    logic [15:0] cmd_window;
    logic [31:0] a_input, b_input;
    logic [31:0] a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b;
    logic        ring_en, count_clr;
    logic [31:0] ring_count;
    logic [31:0] sum_in;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_count, rsp_sum;
    logic        busy;

    int pass_cnt = 0;
    int total    = 0;

    instr_adder_sequencer dut (
        .wb_clk_i          (wb_clk_i),
        .wb_rst_i          (wb_rst_i),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .cmd_ext_b         (cmd_ext_b),
        .cmd_ring_b        (cmd_ring_b),
        .cmd_out_b         (cmd_out_b),
        .cmd_window        (cmd_window),
        .a_input           (a_input),
        .b_input           (b_input),
        .a_input_ext_bit_b (a_input_ext_bit_b),
        .a_input_ring_bit_b(a_input_ring_bit_b),
        .s_output_bit_b    (s_output_bit_b),
        .ring_en           (ring_en),
        .count_clr         (count_clr),
        .ring_count        (ring_count),
        .sum_in            (sum_in),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_count         (rsp_count),
        .rsp_sum           (rsp_sum),
        .busy              (busy)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Adder stub: ring counter ticks once per enabled clock, sum is plain a+b.
    logic [31:0] stub_cnt = 32'd0;
    always @(posedge wb_clk_i) begin
        if (count_clr) stub_cnt <= 32'd0;
        else if (ring_en) stub_cnt <= stub_cnt + 32'd1;
    end
    assign ring_count = stub_cnt;
    assign sum_in     = a_input + b_input;

    function automatic int exp_win(input logic [15:0] w);
        return (w == 16'd0) ? 1 : int'(w);
    endfunction

    function automatic int exp_lat(input logic [15:0] w);
        return PASSES * (1 + SETTLE + exp_win(w) + SETTLE + 1);
    endfunction

    task automatic measure(
        input  logic [31:0] a, b, e, r, o,
        input  logic [15:0] w,
        output int lat, output int ren, output int clr,
        output int rdy_busy, output bit acc_ok, output bit to
    );
        @(negedge wb_clk_i);
        cmd_a = a; cmd_b = b; cmd_ext_b = e;
        cmd_ring_b = r; cmd_out_b = o; cmd_window = w;
        cmd_valid = 1'b1;
        acc_ok = cmd_ready;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        lat = 0;
        ren = int'(ring_en);
        clr = int'(count_clr);
        rdy_busy = int'(cmd_ready);
        while (!rsp_valid && lat < BOUND) begin
            @(posedge wb_clk_i); #1;
            lat++;
            ren += int'(ring_en);
            clr += int'(count_clr);
            rdy_busy += int'(!rsp_valid && cmd_ready);
        end
        to = !rsp_valid;
    endtask

    task automatic handshake();
        @(negedge wb_clk_i);
        rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        total++;
        if (a_input_ext_bit_b !== '1 || a_input_ring_bit_b !== '1 ||
            s_output_bit_b !== '1) begin
            $display("FAIL reset_bit_b: got %h %h %h want ffffffff",
                     a_input_ext_bit_b, a_input_ring_bit_b, s_output_bit_b);
        end else pass_cnt++;
        total++;
        if ({ring_en, count_clr, rsp_valid, busy} !== 4'b0000) begin
            $display("FAIL reset_strobes: got %b want 0000",
                     {ring_en, count_clr, rsp_valid, busy});
        end else pass_cnt++;
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end else pass_cnt++;
        total++;
        if ({a_input, b_input, rsp_count, rsp_sum} !== 128'd0) begin
            $display("FAIL reset_data: got %h %h %h %h want 0",
                     a_input, b_input, rsp_count, rsp_sum);
        end else pass_cnt++;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int lat, ren, clr, rb;
        bit acc, to;
        measure(32'h1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'h0,
                16'd10, lat, ren, clr, rb, acc, to);
        total++;
        if (to || !acc) begin
            $display("FAIL basic_timeout: to=%0b acc=%0b want 0 1", to, acc);
        end else pass_cnt++;
        total++;
        if (lat !== exp_lat(16'd10)) begin
            $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(16'd10));
        end else pass_cnt++;
        total++;
        if (ren !== PASSES * 10 || clr !== PASSES) begin
            $display("FAIL basic_ring: ring=%0d clr=%0d want %0d %0d",
                     ren, clr, PASSES * 10, PASSES);
        end else pass_cnt++;
        total++;
        if (rsp_count !== 32'd10 || rsp_sum !== 32'd0) begin
            $display("FAIL basic_rsp: got %0d %h want 10 0", rsp_count, rsp_sum);
        end else pass_cnt++;
        total++;
        if (a_input !== 32'h1 || a_input_ring_bit_b !== 32'hFFFF_FFFE || rb !== 0) begin
            $display("FAIL basic_drive: a=%h ring=%h ready_busy=%0d", a_input,
                     a_input_ring_bit_b, rb);
        end else pass_cnt++;
        handshake();
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL basic_release: valid=%b ready=%b busy=%b want 0 1 0",
                     rsp_valid, cmd_ready, busy);
        end else pass_cnt++;
    endtask

    task automatic test_window_zero();
        int lat, ren, clr, rb;
        bit acc, to;
        measure(32'h5, 32'h7, 32'h0, 32'h0, 32'h0,
                16'd0, lat, ren, clr, rb, acc, to);
        total++;
        if (to || ren !== PASSES || lat !== exp_lat(16'd0)) begin
            $display("FAIL win0_timing: to=%0b ring=%0d lat=%0d want ring %0d lat %0d",
                     to, ren, lat, PASSES, exp_lat(16'd0));
        end else pass_cnt++;
        total++;
        if (rsp_count !== 32'd1 || rsp_sum !== 32'd12) begin
            $display("FAIL win0_rsp: got %0d %0d want 1 12", rsp_count, rsp_sum);
        end else pass_cnt++;
        handshake();
    endtask

    task automatic test_random();
        int lat, ren, clr, rb;
        bit acc, to;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b, e, r, o;
            logic [15:0] w;
            a = $urandom; b = $urandom; e = $urandom;
            r = $urandom; o = $urandom;
            w = 16'($urandom_range(0, 20));
            measure(a, b, e, r, o, w, lat, ren, clr, rb, acc, to);
            total++;
            if (to || lat !== exp_lat(w) || ren !== PASSES * exp_win(w) ||
                clr !== PASSES) begin
                $display("FAIL rand_timing[%0d]: w=%0d lat=%0d ring=%0d clr=%0d want %0d %0d %0d",
                         i, w, lat, ren, clr, exp_lat(w), PASSES * exp_win(w), PASSES);
            end else pass_cnt++;
            total++;
            if (rsp_count !== 32'(exp_win(w)) || rsp_sum !== a + b) begin
                $display("FAIL rand_rsp[%0d]: got %0d %h want %0d %h",
                         i, rsp_count, rsp_sum, exp_win(w), a + b);
            end else pass_cnt++;
            handshake();
            total++;
            if (a_input !== a || b_input !== b || a_input_ext_bit_b !== e ||
                a_input_ring_bit_b !== r || s_output_bit_b !== o) begin
                $display("FAIL rand_hold[%0d]: adder outputs %h %h %h %h %h want %h %h %h %h %h",
                         i, a_input, b_input, a_input_ext_bit_b, a_input_ring_bit_b,
                         s_output_bit_b, a, b, e, r, o);
            end else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, ren, clr, rb, bad, k;
        bit acc, to;
        logic [31:0] held;
        measure(32'h10, 32'h20, 32'h0, 32'h0, 32'h0,
                16'd3, lat, ren, clr, rb, acc, to);
        held = rsp_count;
        @(negedge wb_clk_i);
        cmd_a = 32'hABCD; cmd_b = 32'h1; cmd_window = 16'd7;
        cmd_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge wb_clk_i); #1;
            if (rsp_valid !== 1'b1 || rsp_count !== held || cmd_ready !== 1'b0 ||
                a_input !== 32'h10) bad++;
        end
        total++;
        if (to || bad !== 0 || held !== 32'd3) begin
            $display("FAIL bp_stable: to=%0b bad_cycles=%0d count=%0d want 0 0 3",
                     to, bad, held);
        end else pass_cnt++;
        @(negedge wb_clk_i);
        rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || a_input !== 32'h10) begin
            $display("FAIL bp_handshake: valid=%b ready=%b a=%h want 0 1 10",
                     rsp_valid, cmd_ready, a_input);
        end else pass_cnt++;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || a_input !== 32'hABCD) begin
            $display("FAIL bp_next_accept: busy=%b a=%h want 1 abcd", busy, a_input);
        end else pass_cnt++;
        k = 0;
        while (!rsp_valid && k < BOUND) begin
            @(posedge wb_clk_i); #1;
            k++;
        end
        total++;
        if (!rsp_valid || rsp_count !== 32'd7 || rsp_sum !== 32'hABCE) begin
            $display("FAIL bp_second_rsp: valid=%b count=%0d sum=%h want 1 7 abce",
                     rsp_valid, rsp_count, rsp_sum);
        end else pass_cnt++;
        handshake();
    endtask

    task automatic test_mid_run_reset();
        int lat, ren, clr, rb, k, seen;
        bit acc, to;
        @(negedge wb_clk_i);
        cmd_a = 32'h3; cmd_b = 32'h4; cmd_ext_b = 32'h0;
        cmd_ring_b = 32'h0; cmd_out_b = 32'h0; cmd_window = 16'd30;
        cmd_valid = 1'b1;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!ring_en && k < 50) begin
            @(posedge wb_clk_i); #1;
            k++;
        end
        total++;
        if (ring_en !== 1'b1) begin
            $display("FAIL rst_reach_run: ring_en=%b want 1", ring_en);
        end else pass_cnt++;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        total++;
        if (ring_en !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
            a_input !== 32'd0 || s_output_bit_b !== '1) begin
            $display("FAIL rst_mid_run: ring=%b valid=%b ready=%b a=%h out_b=%h",
                     ring_en, rsp_valid, cmd_ready, a_input, s_output_bit_b);
        end else pass_cnt++;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge wb_clk_i); #1;
            seen += int'(rsp_valid | ring_en);
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL rst_no_rsp: activity_cycles=%0d want 0", seen);
        end else pass_cnt++;
        measure(32'h8, 32'h9, 32'h0, 32'h0, 32'h0,
                16'd5, lat, ren, clr, rb, acc, to);
        total++;
        if (to || !acc || rsp_count !== 32'd5 || rsp_sum !== 32'd17) begin
            $display("FAIL rst_recover: to=%0b acc=%0b count=%0d sum=%0d want 0 1 5 17",
                     to, acc, rsp_count, rsp_sum);
        end else pass_cnt++;
        handshake();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_ext_b = '0;
        cmd_ring_b = '0; cmd_out_b = '0; cmd_window = '0;
        test_reset();
        test_basic();
        test_window_zero();
        test_random();
        test_back_to_back();
        test_mid_run_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
